hdcp_auth_sniffer: RTL and testbench



---
 rtl/hdcp_auth_sniffer.sv | 199 +++++++++++++++++++
 tb/tb_hdcp_auth_sniffer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hdcp_auth_sniffer.sv
// hdcp_auth_sniffer
// Passive HDCP 1.x authentication sniffer and Km sequencer. It watches the
// decoded DDC byte traffic into the HDCP register space, assembles Bksv,
// Aksv and An, and asks the CPU for Km once the last Aksv byte is written.
// If the CPU does not supply Km in time, HPD is forced low for a while so
// the source starts authentication over.
//
// Ports:
//   clk, rst           pixel clock, asynchronous active-high reset
//   hpd                high when no cable is attached; synchronous clear
//   ddc_wr_stb         source wrote ddc_data at ddc_addr (one-cycle pulse)
//   ddc_rd_stb         source read ddc_data at ddc_addr (one-cycle pulse)
//   ddc_addr/ddc_data  HDCP register offset and byte value
//   cpu_km/cpu_km_wr   Km from the CPU and its one-cycle load strobe
//   An/Aksv/Bksv       assembled session values (byte 0 in bits [7:0])
//   Km/Km_valid        latched Km and its validity for the current Aksv
//   Aksv14_write       one-cycle pulse after the final Aksv byte
//   irq                level Km request to the CPU
//   hpd_force          drive HPD low toward the source
//   an_complete        all 8 An bytes seen since the last clear
//   bksv_complete      all 5 Bksv bytes seen since the last clear
//   sniff_state        current state encoding for debug
module hdcp_auth_sniffer #(
  parameter int                TMR_W      = 24,
  parameter logic [TMR_W-1:0]  KM_TIMEOUT = 24'd12_000_000,
  parameter logic [TMR_W-1:0]  HPD_PULSE  = 24'd7_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hpd,
  input  logic        ddc_wr_stb,
  input  logic        ddc_rd_stb,
  input  logic [7:0]  ddc_addr,
  input  logic [7:0]  ddc_data,
  input  logic [55:0] cpu_km,
  input  logic        cpu_km_wr,
  output logic [63:0] An,
  output logic [39:0] Aksv,
  output logic [39:0] Bksv,
  output logic [55:0] Km,
  output logic        Km_valid,
  output logic        Aksv14_write,
  output logic        irq,
  output logic        hpd_force,
  output logic        an_complete,
  output logic        bksv_complete,
  output logic [2:0]  sniff_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COLLECT   = 3'd1,
    WAIT_KM   = 3'd2,
    KM_READY  = 3'd3,
    FORCE_HPD = 3'd4
  } sniff_state_t;

  // Terminal counts: the timer counts 0..N-1, so N cycles are spent in the state.
  localparam logic [TMR_W-1:0] KM_LAST  = KM_TIMEOUT - TMR_W'(1);
  localparam logic [TMR_W-1:0] HPD_LAST = HPD_PULSE - TMR_W'(1);

  sniff_state_t     state, state_next;
  logic [TMR_W-1:0] timer;
  logic [7:0]       an_mask;
  logic [4:0]       aksv_mask;
  logic [4:0]       bksv_mask;

  logic       capture_en;
  logic       an_hit, aksv_hit, bksv_hit;
  logic       aksv_trig, km_load, km_timeout, pulse_done;
  logic [2:0] byte_sel;
  logic [5:0] byte_base;

  assign byte_sel      = ddc_addr[2:0];
  assign byte_base     = {byte_sel, 3'b000};
  assign an_complete   = &an_mask;
  assign bksv_complete = &bksv_mask;
  assign sniff_state   = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Event decode and next state. hpd masks every event; a write always wins
  // over a read in the same cycle; the Aksv trigger outranks a Km load, which
  // in turn outranks the timeout.
  always_comb begin
    state_next = state;
    capture_en = 1'b0;
    an_hit     = 1'b0;
    aksv_hit   = 1'b0;
    bksv_hit   = 1'b0;
    aksv_trig  = 1'b0;
    km_load    = 1'b0;
    km_timeout = 1'b0;
    pulse_done = 1'b0;

    capture_en = !hpd && (state == COLLECT || state == WAIT_KM || state == KM_READY);
    an_hit     = capture_en && ddc_wr_stb && (ddc_addr[7:3] == 5'b00011);
    aksv_hit   = capture_en && ddc_wr_stb && (ddc_addr[7:3] == 5'b00010) && (byte_sel <= 3'd4);
    bksv_hit   = capture_en && !ddc_wr_stb && ddc_rd_stb &&
                 (ddc_addr[7:3] == 5'b00000) && (byte_sel <= 3'd4);
    aksv_trig  = aksv_hit && (byte_sel == 3'd4);
    km_load    = !hpd && (state == WAIT_KM) && cpu_km_wr && !aksv_trig;
    km_timeout = !hpd && (state == WAIT_KM) && !cpu_km_wr && !aksv_trig && (timer == KM_LAST);
    pulse_done = !hpd && (state == FORCE_HPD) && (timer == HPD_LAST);

    if (hpd) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:      state_next = COLLECT;
        COLLECT:   if (aksv_trig) state_next = WAIT_KM;
        WAIT_KM: begin
          if (aksv_trig)       state_next = WAIT_KM;
          else if (km_load)    state_next = KM_READY;
          else if (km_timeout) state_next = FORCE_HPD;
        end
        KM_READY:  if (aksv_trig) state_next = WAIT_KM;
        FORCE_HPD: if (pulse_done) state_next = COLLECT;
        default:   state_next = IDLE;
      endcase
    end
  end

  // Shared timer for the Km wait and the forced HPD pulse; saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (hpd || aksv_trig || km_timeout || pulse_done) begin
      timer <= '0;
    end else if (state == WAIT_KM || state == FORCE_HPD) begin
      if (timer != '1) timer <= timer + TMR_W'(1);
    end else begin
      timer <= '0;
    end
  end

  // Byte-seen masks. A Km load clears An/Aksv tracking (Bksv stays valid
  // across sessions); a byte captured in that same cycle still marks itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_mask   <= '0;
      aksv_mask <= '0;
      bksv_mask <= '0;
    end else if (hpd || pulse_done) begin
      an_mask   <= '0;
      aksv_mask <= '0;
      bksv_mask <= '0;
    end else begin
      if (km_load) begin
        an_mask   <= '0;
        aksv_mask <= '0;
      end
      if (an_hit)   an_mask[byte_sel]   <= 1'b1;
      if (aksv_hit) aksv_mask[byte_sel] <= 1'b1;
      if (bksv_hit) bksv_mask[byte_sel] <= 1'b1;
    end
  end

  // Captured values survive hpd; only the handshake flags are cleared by it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      An           <= '0;
      Aksv         <= '0;
      Bksv         <= '0;
      Km           <= '0;
      Km_valid     <= 1'b0;
      Aksv14_write <= 1'b0;
      irq          <= 1'b0;
      hpd_force    <= 1'b0;
    end else begin
      Aksv14_write <= aksv_trig;
      if (an_hit)   An[byte_base +: 8]   <= ddc_data;
      if (aksv_hit) Aksv[byte_base +: 8] <= ddc_data;
      if (bksv_hit) Bksv[byte_base +: 8] <= ddc_data;
      if (km_load)  Km <= cpu_km;
      if (hpd) begin
        Km_valid  <= 1'b0;
        irq       <= 1'b0;
        hpd_force <= 1'b0;
      end else begin
        if (aksv_trig) begin
          Km_valid <= 1'b0;
          irq      <= 1'b1;
        end else if (km_load) begin
          Km_valid <= 1'b1;
          irq      <= 1'b0;
        end else if (km_timeout) begin
          irq       <= 1'b0;
          hpd_force <= 1'b1;
        end
        if (pulse_done) hpd_force <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hdcp_auth_sniffer.sv
// Testbench for hdcp_auth_sniffer: directed walk through an authentication
// session (capture, Km hand-off, re-auth, collisions, timeout, unplug, reset)
// followed by randomized DDC/CPU traffic compared every cycle against a
// behavioural model built from byte arrays and an elapsed-cycle count.
module tb_hdcp_auth_sniffer;
  localparam int KM_TO = 10;
  localparam int HPD_P = 5;
  localparam int M_IDLE = 0, M_COLLECT = 1, M_WAIT = 2, M_READY = 3, M_FORCE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hpd = 1'b1;
  logic        ddc_wr_stb = 1'b0;
  logic        ddc_rd_stb = 1'b0;
  logic [7:0]  ddc_addr = 8'h00;
  logic [7:0]  ddc_data = 8'h00;
  logic [55:0] cpu_km = '0;
  logic        cpu_km_wr = 1'b0;
  logic [63:0] An;
  logic [39:0] Aksv, Bksv;
  logic [55:0] Km;
  logic        Km_valid, Aksv14_write, irq, hpd_force, an_complete, bksv_complete;
  logic [2:0]  sniff_state;

  hdcp_auth_sniffer #(
    .TMR_W(24), .KM_TIMEOUT(24'(KM_TO)), .HPD_PULSE(24'(HPD_P))
  ) dut (
    .clk(clk), .rst(rst), .hpd(hpd),
    .ddc_wr_stb(ddc_wr_stb), .ddc_rd_stb(ddc_rd_stb),
    .ddc_addr(ddc_addr), .ddc_data(ddc_data),
    .cpu_km(cpu_km), .cpu_km_wr(cpu_km_wr),
    .An(An), .Aksv(Aksv), .Bksv(Bksv), .Km(Km), .Km_valid(Km_valid),
    .Aksv14_write(Aksv14_write), .irq(irq), .hpd_force(hpd_force),
    .an_complete(an_complete), .bksv_complete(bksv_complete),
    .sniff_state(sniff_state)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: phase, cycles elapsed in the timed phases, byte arrays.
  int          m_mode;
  int          m_cnt;
  logic [7:0]  m_an [8];
  logic [7:0]  m_aksv [5];
  logic [7:0]  m_bksv [5];
  bit   [7:0]  m_anSeen;
  bit   [4:0]  m_aksvSeen, m_bksvSeen;
  logic [55:0] m_km;
  bit          m_kmv, m_irq, m_force, m_pulse;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic modelReset();
    m_mode = M_IDLE; m_cnt = 0; m_km = '0;
    m_kmv = 0; m_irq = 0; m_force = 0; m_pulse = 0;
    m_anSeen = '0; m_aksvSeen = '0; m_bksvSeen = '0;
    for (int i = 0; i < 8; i++) m_an[i] = 8'h00;
    for (int i = 0; i < 5; i++) begin m_aksv[i] = 8'h00; m_bksv[i] = 8'h00; end
  endtask

  task automatic modelStep();
    bit live, trig;
    int a;
    a = int'(ddc_addr);
    m_pulse = 0;
    if (hpd) begin
      m_mode = M_IDLE; m_cnt = 0; m_kmv = 0; m_irq = 0; m_force = 0;
      m_anSeen = '0; m_aksvSeen = '0; m_bksvSeen = '0;
      return;
    end
    live = (m_mode == M_COLLECT) || (m_mode == M_WAIT) || (m_mode == M_READY);
    trig = live && ddc_wr_stb && (a == 'h14);
    case (m_mode)
      M_IDLE: m_mode = M_COLLECT;
      M_FORCE: begin
        m_cnt++;
        if (m_cnt == HPD_P) begin
          m_mode = M_COLLECT; m_force = 0; m_cnt = 0;
          m_anSeen = '0; m_aksvSeen = '0; m_bksvSeen = '0;
        end
      end
      default: begin
        if (trig) begin
          m_pulse = 1; m_kmv = 0; m_irq = 1; m_cnt = 0; m_mode = M_WAIT;
        end else if (m_mode == M_WAIT && cpu_km_wr) begin
          m_km = cpu_km; m_kmv = 1; m_irq = 0; m_mode = M_READY;
          m_anSeen = '0; m_aksvSeen = '0;
        end else if (m_mode == M_WAIT) begin
          m_cnt++;
          if (m_cnt == KM_TO) begin
            m_irq = 0; m_force = 1; m_mode = M_FORCE; m_cnt = 0;
          end
        end
      end
    endcase
    if (live && ddc_wr_stb) begin
      if (a >= 'h18 && a <= 'h1F) begin m_an[a - 'h18] = ddc_data; m_anSeen[a - 'h18] = 1; end
      if (a >= 'h10 && a <= 'h14) begin m_aksv[a - 'h10] = ddc_data; m_aksvSeen[a - 'h10] = 1; end
    end else if (live && ddc_rd_stb && a <= 4) begin
      m_bksv[a] = ddc_data; m_bksvSeen[a] = 1;
    end
  endtask

  function automatic logic [63:0] expAn();
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = m_an[i];
    return v;
  endfunction

  function automatic logic [39:0] pack5(input logic [7:0] b0, b1, b2, b3, b4);
    return {b4, b3, b2, b1, b0};
  endfunction

  task automatic compareAll(input string tag);
    checkOutput({tag, ":An"}, An, expAn());
    checkOutput({tag, ":Aksv"}, 64'(Aksv), 64'(pack5(m_aksv[0], m_aksv[1], m_aksv[2], m_aksv[3], m_aksv[4])));
    checkOutput({tag, ":Bksv"}, 64'(Bksv), 64'(pack5(m_bksv[0], m_bksv[1], m_bksv[2], m_bksv[3], m_bksv[4])));
    checkOutput({tag, ":Km"}, 64'(Km), 64'(m_km));
    checkOutput({tag, ":Km_valid"}, 64'(Km_valid), 64'(m_kmv));
    checkOutput({tag, ":Aksv14_write"}, 64'(Aksv14_write), 64'(m_pulse));
    checkOutput({tag, ":irq"}, 64'(irq), 64'(m_irq));
    checkOutput({tag, ":hpd_force"}, 64'(hpd_force), 64'(m_force));
    checkOutput({tag, ":an_complete"}, 64'(an_complete), 64'(m_anSeen == 8'hFF));
    checkOutput({tag, ":bksv_complete"}, 64'(bksv_complete), 64'(m_bksvSeen == 5'h1F));
    checkOutput({tag, ":state"}, 64'(sniff_state), 64'(m_mode));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ":zero_keys"}, An | 64'(Aksv) | 64'(Bksv) | 64'(Km), 64'h0);
    checkOutput({tag, ":zero_flags"},
                64'({Km_valid, Aksv14_write, irq, hpd_force, an_complete, bksv_complete, sniff_state}), 64'h0);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) modelReset();
    else     modelStep();
    #1;
    compareAll(tag);
  endtask

  task automatic applyStimulus(input string tag, input bit wr, input bit rd, input logic [7:0] addr,
                               input logic [7:0] data, input bit kmwr, input logic [55:0] km);
    ddc_wr_stb = wr; ddc_rd_stb = rd; ddc_addr = addr; ddc_data = data;
    cpu_km_wr = kmwr; cpu_km = km;
    tick(tag);
    ddc_wr_stb = 1'b0; ddc_rd_stb = 1'b0; cpu_km_wr = 1'b0;
  endtask

  task automatic idleCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(tag, 0, 0, 8'h00, 8'h00, 0, '0);
  endtask

  initial begin
    modelReset();
    #1;
    checkAllZero("async_reset");
    tick("reset");
    rst = 1'b0; hpd = 1'b0;
    tick("idle_to_collect");

    // Normal authentication
    for (int i = 0; i < 5; i++) applyStimulus("bksv_rd", 0, 1, 8'(i), 8'(i + 1), 0, '0);
    for (int i = 0; i < 8; i++) applyStimulus("an_wr", 1, 0, 8'(8'h18 + i), 8'(8'h11 + i), 0, '0);
    for (int i = 0; i < 5; i++) applyStimulus("aksv_wr", 1, 0, 8'(8'h10 + i), 8'(8'h21 + i), 0, '0);
    checkOutput("auth:Bksv", 64'(Bksv), 64'h0504030201);
    checkOutput("auth:An", An, 64'h1817161514131211);
    checkOutput("auth:Aksv", 64'(Aksv), 64'h2524232221);
    checkOutput("auth:pulse", 64'(Aksv14_write), 64'd1);
    checkOutput("auth:irq", 64'(irq), 64'd1);
    checkOutput("auth:state", 64'(sniff_state), 64'd2);
    idleCycles(1, "auth_after");
    checkOutput("auth:pulse_once", 64'(Aksv14_write), 64'd0);
    applyStimulus("km_load", 0, 0, 8'h00, 8'h00, 1, 56'h00AABBCCDDEEFF);
    checkOutput("km:Km", 64'(Km), 64'h00AABBCCDDEEFF);
    checkOutput("km:flags", 64'({Km_valid, irq, sniff_state}), 64'b1_0_011);

    // Re-auth from KM_READY, then collision of 0x14 with a Km write
    applyStimulus("reauth", 1, 0, 8'h14, 8'h35, 0, '0);
    checkOutput("reauth:flags", 64'({Km_valid, Aksv14_write, irq, sniff_state}), 64'b0_1_1_010);
    idleCycles(5, "reauth_wait");
    applyStimulus("collide", 1, 0, 8'h14, 8'h36, 1, 56'h11223344556677);
    checkOutput("collide:Km", 64'(Km), 64'h00AABBCCDDEEFF);
    checkOutput("collide:state", 64'(sniff_state), 64'd2);

    // Timeout measured from the collision (timer restarted there)
    idleCycles(KM_TO - 1, "timeout_wait");
    checkOutput("timeout:early", 64'(hpd_force), 64'd0);
    idleCycles(1, "timeout_rise");
    checkOutput("timeout:rise", 64'({hpd_force, irq, sniff_state}), 64'b1_0_100);
    idleCycles(HPD_P - 1, "force_hold");
    checkOutput("timeout:hold", 64'(hpd_force), 64'd1);
    idleCycles(1, "force_end");
    checkOutput("timeout:end", 64'({hpd_force, bksv_complete, sniff_state}), 64'b0_0_001);

    // Ignored traffic and same-cycle read/write in COLLECT
    applyStimulus("ign_08", 1, 0, 8'h08, 8'h99, 0, '0);
    applyStimulus("ign_20", 1, 0, 8'h20, 8'h98, 0, '0);
    applyStimulus("ign_km", 0, 0, 8'h00, 8'h00, 1, 56'h0F0F0F0F0F0F0F);
    checkOutput("ign:Km", 64'(Km), 64'h00AABBCCDDEEFF);
    checkOutput("ign:flags", 64'({Km_valid, irq, sniff_state}), 64'b0_0_001);
    applyStimulus("rdwr", 1, 1, 8'h03, 8'h77, 0, '0);
    checkOutput("rdwr:Bksv", 64'(Bksv), 64'h0504030201);
    checkOutput("rdwr:bksv_complete", 64'(bksv_complete), 64'd0);

    // Unplug mid-WAIT_KM
    for (int i = 0; i < 8; i++) applyStimulus("an_wr2", 1, 0, 8'(8'h18 + i), 8'(8'h11 + i), 0, '0);
    applyStimulus("trig2", 1, 0, 8'h14, 8'h25, 0, '0);
    hpd = 1'b1;
    tick("unplug");
    checkOutput("unplug:flags", 64'({irq, Km_valid, an_complete, sniff_state}), 64'b0_0_0_000);
    checkOutput("unplug:An", An, 64'h1817161514131211);
    hpd = 1'b0;
    tick("replug");

    // Asynchronous reset mid-operation
    applyStimulus("pre_rst", 1, 0, 8'h14, 8'h44, 0, '0);
    #2 rst = 1'b1;
    #1 checkAllZero("mid_reset");
    tick("mid_reset_edge");
    rst = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] a;
      case ($urandom_range(0, 3))
        0:       a = 8'($urandom_range(0, 4));
        1:       a = 8'(8'h10 + $urandom_range(0, 4));
        2:       a = 8'(8'h18 + $urandom_range(0, 7));
        default: a = 8'($urandom());
      endcase
      hpd = ($urandom_range(0, 63) == 0);
      applyStimulus("rand", $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3, a,
                    8'($urandom()), $urandom_range(0, 9) == 0, 56'({$urandom(), $urandom()}));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
